// File: rtl/encoder_seq_pkg.sv
// ----------------------------------------------------------------------------
// encoder_seq_pkg
// Shared types for the encoder stimulus sequencer:
//   ENC_W        - width of the encoder model's configuration fields
//   seq_state_t  - sequencer FSM states (IDLE, LOAD, RUN, GAP)
//   cmd_t        - one queued motion segment, 50 bits packed
//   cmd_is_valid - acceptance rule applied to a segment when it is popped
// ----------------------------------------------------------------------------
package encoder_seq_pkg;

    localparam int ENC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [ENC_W-1:0] period_number;
        logic [ENC_W-1:0] half;
        logic [ENC_W-1:0] period;
        logic             direction;
        logic             quad_en;
    } cmd_t;

    // A segment needs a non-zero period and a high phase that ends before
    // the period terminal value, otherwise the model never toggles.
    function automatic logic cmd_is_valid(input cmd_t c);
        return (c.period != '0) && (c.half < c.period);
    endfunction

endpackage

// File: rtl/encoder_cmd_fifo.sv
// ----------------------------------------------------------------------------
// encoder_cmd_fifo
// Synchronous FIFO of segment commands with a synchronous flush.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   flush       - empties the FIFO this cycle (wins over push/pop)
//   push, data  - write request and the command to store
//   pop         - read request; head advances when not empty
//   head        - command at the head of the queue (valid when !empty)
//   full, empty - occupancy flags
// ----------------------------------------------------------------------------
module encoder_cmd_fifo
    import encoder_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    input  logic push,
    input  cmd_t data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    cmd_t        mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push while full still fits.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= data;
    end

endmodule

// File: rtl/encoder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// encoder_seq_ctrl
// Sequences queued motion segments onto the encoder stimulus model: loads a
// segment's configuration, enables the model for the segment's duration,
// then holds enable low for an idle gap before taking the next segment.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   cmd_*                - segment command push interface (valid/ready)
//   abort                - level; stops the running segment, flushes queue
//   enc_*                - configuration and enable pins of the model
//   busy                 - sequencer active or commands pending
//   seg_done/seg_aborted - one-cycle completion / abort pulses
//   cmd_err              - one-cycle pulse for a rejected command
//   seg_count            - number of normally completed segments (wraps)
// ----------------------------------------------------------------------------
module encoder_seq_ctrl
    import encoder_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 4,
    parameter int START_LAT  = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ENC_W-1:0] cmd_period_number,
    input  logic [ENC_W-1:0] cmd_half,
    input  logic [ENC_W-1:0] cmd_period,
    input  logic             cmd_direction,
    input  logic             cmd_quad_en,
    input  logic             abort,
    output logic [ENC_W-1:0] enc_period_number,
    output logic [ENC_W-1:0] enc_half,
    output logic [ENC_W-1:0] enc_period,
    output logic             enc_direction,
    output logic             enc_direct_enable,
    output logic             enc_quadrature_enable,
    output logic             busy,
    output logic             seg_done,
    output logic             seg_aborted,
    output logic             cmd_err,
    output logic [ENC_W-1:0] seg_count
);

    localparam logic [ENC_W-1:0] LAT_LAST = ENC_W'(START_LAT - 1);
    localparam logic [ENC_W-1:0] GAP_LAST = ENC_W'(GAP_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    cmd_t             push_cmd;
    cmd_t             head;
    cmd_t             enc_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ready_q;
    logic             push;
    logic             pop;
    logic             head_ok;
    logic             last_run_cycle;
    logic             gap_done;
    logic             lat_done;
    logic [ENC_W-1:0] lat_cnt;
    logic [ENC_W-1:0] per_cnt;
    logic [ENC_W-1:0] rep_cnt;
    logic [ENC_W-1:0] gap_cnt;

    assign push_cmd = '{period_number: cmd_period_number, half: cmd_half,
                        period: cmd_period, direction: cmd_direction,
                        quad_en: cmd_quad_en};

    // ready_q keeps cmd_ready low while reset is asserted.
    assign cmd_ready = ready_q && !fifo_full && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == LOAD);
    assign head_ok   = cmd_is_valid(head);
    assign busy      = (state != IDLE) || !fifo_empty;

    assign enc_period_number     = enc_q.period_number;
    assign enc_half              = enc_q.half;
    assign enc_period            = enc_q.period;
    assign enc_direction         = enc_q.direction;
    assign enc_quadrature_enable = enc_q.quad_en;
    // Decoded from the asynchronously reset state so it drops with rstn.
    assign enc_direct_enable     = (state == RUN);

    // period_number == 0 never ends on its own, even once rep_cnt saturates.
    assign last_run_cycle = lat_done && (enc_q.period_number != '0) &&
                            (rep_cnt == enc_q.period_number - ENC_W'(1)) &&
                            (per_cnt == enc_q.period);
    assign gap_done       = (gap_cnt == GAP_LAST);

    encoder_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (abort),
        .push  (push),
        .data  (push_cmd),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Abort takes priority everywhere: the queue is being flushed, so IDLE
    // must not move to LOAD and a completing segment is reported as aborted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!fifo_empty && !abort) state_next = LOAD;
            LOAD: state_next = (abort || !head_ok) ? IDLE : RUN;
            RUN:  if (abort || last_run_cycle) state_next = GAP;
            GAP:  if (!abort && gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q     <= 1'b0;
            enc_q       <= '0;
            seg_done    <= 1'b0;
            seg_aborted <= 1'b0;
            cmd_err     <= 1'b0;
            seg_count   <= '0;
            lat_cnt     <= '0;
            lat_done    <= 1'b0;
            per_cnt     <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            ready_q     <= 1'b1;
            seg_done    <= (state == RUN) && last_run_cycle && !abort;
            seg_aborted <= (state == RUN) && abort;
            cmd_err     <= (state == LOAD) && !abort && !head_ok;

            if ((state == RUN) && last_run_cycle && !abort)
                seg_count <= seg_count + ENC_W'(1);

            // A rejected command leaves the model configuration cleared.
            if ((state == LOAD) && !abort) begin
                enc_q    <= head_ok ? head : '0;
                lat_cnt  <= '0;
                lat_done <= (START_LAT == 0);
                per_cnt  <= '0;
                rep_cnt  <= '0;
            end

            // Start latency first, then period/repetition counting.
            if (state == RUN) begin
                if (!lat_done) begin
                    if (lat_cnt == LAT_LAST) lat_done <= 1'b1;
                    else                     lat_cnt  <= lat_cnt + ENC_W'(1);
                end else if (per_cnt == enc_q.period) begin
                    per_cnt <= '0;
                    if (rep_cnt != '1) rep_cnt <= rep_cnt + ENC_W'(1);
                end else begin
                    per_cnt <= per_cnt + ENC_W'(1);
                end
            end

            // Held abort keeps the gap count at zero so the gap restarts.
            if ((state != GAP) || abort) gap_cnt <= '0;
            else if (!gap_done)          gap_cnt <= gap_cnt + ENC_W'(1);
        end
    end

endmodule

// File: tb/tb_encoder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_encoder_seq_ctrl
// Self-checking bench for encoder_seq_ctrl. A negedge monitor records every
// enable pulse (length and configuration seen at its start); each test
// compares those records with the durations and fields the commands it
// pushed should produce.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder_seq_ctrl;
    import encoder_seq_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYCLES = 4;
    localparam int START_LAT  = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_period_number = '0;
    logic [15:0] cmd_half = '0;
    logic [15:0] cmd_period = '0;
    logic        cmd_direction = 1'b0;
    logic        cmd_quad_en = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] enc_period_number;
    logic [15:0] enc_half;
    logic [15:0] enc_period;
    logic        enc_direction;
    logic        enc_direct_enable;
    logic        enc_quadrature_enable;
    logic        busy;
    logic        seg_done;
    logic        seg_aborted;
    logic        cmd_err;
    logic [15:0] seg_count;

    int checks = 0;
    int errors = 0;
    int exp_seg_count = 0;

    encoder_seq_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES),
        .START_LAT  (START_LAT)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_period_number     (cmd_period_number),
        .cmd_half              (cmd_half),
        .cmd_period            (cmd_period),
        .cmd_direction         (cmd_direction),
        .cmd_quad_en           (cmd_quad_en),
        .abort                 (abort),
        .enc_period_number     (enc_period_number),
        .enc_half              (enc_half),
        .enc_period            (enc_period),
        .enc_direction         (enc_direction),
        .enc_direct_enable     (enc_direct_enable),
        .enc_quadrature_enable (enc_quadrature_enable),
        .busy                  (busy),
        .seg_done              (seg_done),
        .seg_aborted           (seg_aborted),
        .cmd_err               (cmd_err),
        .seg_count             (seg_count)
    );

    always #5 clk = ~clk;

    // Reference model: a command runs only if its period is non-zero and
    // the high phase ends before the period; it then enables the model for
    // the start latency plus period_number full periods of period+1 clocks.
    function automatic bit cmd_ok(input cmd_t c);
        return (c.period > 0) && (c.half < c.period);
    endfunction

    function automatic int seg_len(input cmd_t c);
        return START_LAT + int'(c.period_number) * (int'(c.period) + 1);
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.period_number = 16'($urandom_range(1, 3));
        c.period        = 16'($urandom_range(0, 6));
        c.half          = 16'($urandom_range(0, 7));
        c.direction     = 1'($urandom_range(0, 1));
        c.quad_en       = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Monitor state
    cmd_t sent[$];
    int   pulse_lens[$];
    cmd_t pulse_cmds[$];
    int   pulse_len, low_run, min_gap;
    int   err_pulses, done_pulses, abort_pulses, unstable, done_misplaced;
    bit   prev_en, have_prev;
    cmd_t pulse_cfg;

    always @(negedge clk) begin
        cmd_t cur;
        cur = {enc_period_number, enc_half, enc_period, enc_direction, enc_quadrature_enable};
        if (!rstn) begin
            prev_en = 1'b0;
        end else begin
            if (enc_direct_enable) begin
                if (!prev_en) begin
                    if (have_prev && low_run < min_gap) min_gap = low_run;
                    pulse_len = 0;
                    pulse_cfg = cur;
                end
                pulse_len++;
                if (cur !== pulse_cfg) unstable++;
            end else begin
                if (prev_en) begin
                    pulse_lens.push_back(pulse_len);
                    pulse_cmds.push_back(pulse_cfg);
                    have_prev = 1'b1;
                    low_run = 0;
                end
                low_run++;
            end
            if (seg_done && !(prev_en && !enc_direct_enable)) done_misplaced++;
            if (seg_done)    done_pulses++;
            if (seg_aborted) abort_pulses++;
            if (cmd_err)     err_pulses++;
            prev_en = enc_direct_enable;
        end
    end

    task automatic clear_mon();
        sent.delete();
        pulse_lens.delete();
        pulse_cmds.delete();
        err_pulses = 0; done_pulses = 0; abort_pulses = 0;
        unstable = 0; done_misplaced = 0;
        have_prev = 1'b0; low_run = 0; min_gap = 1000000;
    endtask

    task automatic push_cmd(input cmd_t c);
        int t = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_period_number = c.period_number;
        cmd_half = c.half;
        cmd_period = c.period;
        cmd_direction = c.direction;
        cmd_quad_en = c.quad_en;
        while (!cmd_ready && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("[TB] FAIL push_timeout: cmd_ready=%0b after %0d cycles, expected 1", cmd_ready, t);
        end else begin
            sent.push_back(c);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        @(negedge clk);
        while (busy && t < max) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checks++; errors++;
            $display("[TB] FAIL wait_idle: busy=%0b after %0d cycles, expected 0", busy, t);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_enable(input int max);
        int t = 0;
        while (!enc_direct_enable && t < max) begin
            @(posedge clk); #1;
            t++;
        end
        if (!enc_direct_enable) begin
            checks++; errors++;
            $display("[TB] FAIL wait_enable: enable=%0b after %0d cycles, expected 1", enc_direct_enable, t);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, enc_direct_enable, busy, seg_done, seg_aborted, cmd_err, seg_count,
             enc_period_number, enc_half, enc_period, enc_direction, enc_quadrature_enable} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: en=%0b busy=%0b cnt=%0d period=%0d, expected all 0",
                     enc_direct_enable, busy, seg_count, enc_period);
        end
        rstn = 1'b1;
        exp_seg_count = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: cmd_ready=%0b busy=%0b, expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        cmd_t c = '{period_number: 16'd2, half: 16'd1, period: 16'd3, direction: 1'b1, quad_en: 1'b1};
        clear_mon();
        push_cmd(c);
        wait_idle(200);
        exp_seg_count++;
        checks++;
        if (pulse_lens.size() != 1 || pulse_lens[0] != seg_len(c) || pulse_cmds[0] !== c) begin
            errors++;
            $display("[TB] FAIL single_pulse: pulses=%0d len=%0d, expected 1 pulse of %0d",
                     pulse_lens.size(), (pulse_lens.size() > 0) ? pulse_lens[0] : -1, seg_len(c));
        end
        checks++;
        if (done_pulses != 1 || done_misplaced != 0) begin
            errors++;
            $display("[TB] FAIL single_done: done=%0d misplaced=%0d, expected 1/0", done_pulses, done_misplaced);
        end
        checks++;
        if (seg_count !== exp_seg_count[15:0]) begin
            errors++;
            $display("[TB] FAIL single_count: seg_count=%0d, expected %0d", seg_count, exp_seg_count);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            cmd_t c;
            c.period_number = 16'd1;
            c.period = 16'd7;
            c.half = 16'($urandom_range(0, 6));
            c.direction = 1'($urandom_range(0, 1));
            c.quad_en = 1'($urandom_range(0, 1));
            push_cmd(c);
        end
        wait_idle(300);
        foreach (sent[i]) begin
            checks++;
            if (k >= pulse_lens.size() || pulse_lens[k] != seg_len(sent[i]) || pulse_cmds[k] !== sent[i]) begin
                errors++;
                $display("[TB] FAIL b2b_seg%0d: pulses=%0d, expected len %0d cfg %h", k,
                         pulse_lens.size(), seg_len(sent[i]), sent[i]);
            end
            k++;
        end
        exp_seg_count += k;
        checks++;
        if (min_gap < GAP_CYCLES || unstable != 0) begin
            errors++;
            $display("[TB] FAIL b2b_gap: min_gap=%0d unstable=%0d, expected >=%0d/0", min_gap, unstable, GAP_CYCLES);
        end
        checks++;
        if (seg_count !== exp_seg_count[15:0] || done_pulses != 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: seg_count=%0d done=%0d, expected %0d/3", seg_count, done_pulses, exp_seg_count);
        end
    endtask

    task automatic test_invalid();
        cmd_t bad  = '{period_number: 16'd1, half: 16'd5, period: 16'd5, direction: 1'b0, quad_en: 1'b1};
        cmd_t good = '{period_number: 16'd1, half: 16'd0, period: 16'd2, direction: 1'b1, quad_en: 1'b0};
        clear_mon();
        push_cmd(bad);
        push_cmd(good);
        wait_idle(200);
        exp_seg_count++;
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("[TB] FAIL invalid_err: cmd_err pulses=%0d, expected 1", err_pulses);
        end
        checks++;
        if (pulse_lens.size() != 1 || pulse_lens[0] != seg_len(good) || pulse_cmds[0] !== good) begin
            errors++;
            $display("[TB] FAIL invalid_next: pulses=%0d, expected 1 pulse of %0d", pulse_lens.size(), seg_len(good));
        end
        checks++;
        if (seg_count !== exp_seg_count[15:0]) begin
            errors++;
            $display("[TB] FAIL invalid_count: seg_count=%0d, expected %0d", seg_count, exp_seg_count);
        end
    endtask

    task automatic test_fifo_full();
        int k = 0, nerr = 0, ready_seen = 0;
        cmd_t longc = '{period_number: 16'd1, half: 16'd0, period: 16'd150, direction: 1'b0, quad_en: 1'b0};
        clear_mon();
        push_cmd(longc);
        wait_enable(20);
        for (int i = 0; i < FIFO_DEPTH; i++) push_cmd(rand_cmd());
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) ready_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (ready_seen != 0 || sent.size() != FIFO_DEPTH + 1) begin
            errors++;
            $display("[TB] FAIL fifo_full_ready: ready_cycles=%0d accepted=%0d, expected 0/%0d",
                     ready_seen, sent.size(), FIFO_DEPTH + 1);
        end
        push_cmd(rand_cmd());
        wait_idle(2000);
        foreach (sent[i]) begin
            if (cmd_ok(sent[i])) begin
                checks++;
                if (k >= pulse_lens.size() || pulse_lens[k] != seg_len(sent[i]) || pulse_cmds[k] !== sent[i]) begin
                    errors++;
                    $display("[TB] FAIL fifo_seg%0d: pulses=%0d, expected len %0d cfg %h", k,
                             pulse_lens.size(), seg_len(sent[i]), sent[i]);
                end
                k++;
            end else nerr++;
        end
        exp_seg_count += k;
        checks++;
        if (pulse_lens.size() != k || err_pulses != nerr || seg_count !== exp_seg_count[15:0]) begin
            errors++;
            $display("[TB] FAIL fifo_totals: pulses=%0d errs=%0d cnt=%0d, expected %0d/%0d/%0d",
                     pulse_lens.size(), err_pulses, seg_count, k, nerr, exp_seg_count);
        end
    endtask

    task automatic test_infinite_abort();
        int low_cnt = 0;
        cmd_t inf = '{period_number: 16'd0, half: 16'd1, period: 16'd3, direction: 1'b1, quad_en: 1'b1};
        cmd_t extra = '{period_number: 16'd1, half: 16'd1, period: 16'd4, direction: 1'b0, quad_en: 1'b1};
        clear_mon();
        push_cmd(inf);
        wait_enable(20);
        push_cmd(extra);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!enc_direct_enable) low_cnt++;
        end
        checks++;
        if (low_cnt != 0 || !busy) begin
            errors++;
            $display("[TB] FAIL infinite_hold: low_cycles=%0d busy=%0b, expected 0/1", low_cnt, busy);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (enc_direct_enable !== 1'b0 || seg_aborted !== 1'b1 || seg_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_response: en=%0b aborted=%0b done=%0b, expected 0/1/0",
                     enc_direct_enable, seg_aborted, seg_done);
        end
        repeat (GAP_CYCLES - 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_gap_busy: busy=%0b in last gap cycle, expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_busy_clear: busy=%0b after gap, expected 0", busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (pulse_lens.size() != 1 || abort_pulses != 1 || done_pulses != 0 || seg_count !== exp_seg_count[15:0]) begin
            errors++;
            $display("[TB] FAIL abort_flush: pulses=%0d aborted=%0d done=%0d cnt=%0d, expected 1/1/0/%0d",
                     pulse_lens.size(), abort_pulses, done_pulses, seg_count, exp_seg_count);
        end
    endtask

    task automatic test_abort_last();
        cmd_t c = '{period_number: 16'd1, half: 16'd1, period: 16'd3, direction: 1'b0, quad_en: 1'b1};
        clear_mon();
        push_cmd(c);
        wait_enable(20);
        repeat (seg_len(c) - 1) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (seg_aborted !== 1'b1 || seg_done !== 1'b0 || enc_direct_enable !== 1'b0 ||
            seg_count !== exp_seg_count[15:0]) begin
            errors++;
            $display("[TB] FAIL abort_last: aborted=%0b done=%0b en=%0b cnt=%0d, expected 1/0/0/%0d",
                     seg_aborted, seg_done, enc_direct_enable, seg_count, exp_seg_count);
        end
        wait_idle(100);
        checks++;
        if (pulse_lens.size() != 1 || pulse_lens[0] != seg_len(c) || done_pulses != 0) begin
            errors++;
            $display("[TB] FAIL abort_last_pulse: pulses=%0d done=%0d, expected 1 pulse of %0d, 0 done",
                     pulse_lens.size(), done_pulses, seg_len(c));
        end
    endtask

    task automatic test_reset_mid_run();
        cmd_t c = '{period_number: 16'd0, half: 16'd2, period: 16'd5, direction: 1'b1, quad_en: 1'b1};
        clear_mon();
        push_cmd(c);
        wait_enable(20);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        exp_seg_count = 0;
        checks++;
        if ({cmd_ready, enc_direct_enable, busy, seg_done, seg_aborted, cmd_err, seg_count,
             enc_period_number, enc_half, enc_period, enc_direction, enc_quadrature_enable} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: en=%0b busy=%0b cnt=%0d period=%0d, expected all 0",
                     enc_direct_enable, busy, seg_count, enc_period);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int k = 0, nerr = 0;
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            push_cmd(rand_cmd());
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end
        wait_idle(3000);
        foreach (sent[i]) begin
            if (cmd_ok(sent[i])) begin
                checks++;
                if (k >= pulse_lens.size() || pulse_lens[k] != seg_len(sent[i]) || pulse_cmds[k] !== sent[i]) begin
                    errors++;
                    $display("[TB] FAIL random_seg%0d: pulses=%0d, expected len %0d cfg %h", k,
                             pulse_lens.size(), seg_len(sent[i]), sent[i]);
                end
                k++;
            end else nerr++;
        end
        exp_seg_count += k;
        checks++;
        if (pulse_lens.size() != k || err_pulses != nerr || seg_count !== exp_seg_count[15:0] ||
            unstable != 0 || done_misplaced != 0 || (k > 1 && min_gap < GAP_CYCLES)) begin
            errors++;
            $display("[TB] FAIL random_totals: pulses=%0d errs=%0d cnt=%0d unstable=%0d gap=%0d, expected %0d/%0d/%0d/0/>=%0d",
                     pulse_lens.size(), err_pulses, seg_count, unstable, min_gap, k, nerr, exp_seg_count, GAP_CYCLES);
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_invalid();
        test_fifo_full();
        test_infinite_abort();
        test_abort_last();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
